gpio_bank_ctrl: RTL

Parametrised multi-port GPIO peripheral, the next-generation replacement for the single 8-bit GPIO on the RISC-V multi-cycle memory map.
- Provides NUM_PORTS ports of PORT_WIDTH pins each.
- Each pin has a direction register, a 2-flop input synchroniser, and per-pin rising/falling edge capture into a W1C status register.
- A single combined irq output is driven from the status registers.
- Sits behind Mem_Map_Controler on the core's re/we/A/WD/RD bus, with 1-cycle registered read data.

---
 rtl/gpio_bank_pkg.sv | 21 ++
 rtl/gpio_edge_sync.sv | 81 ++++++++
 rtl/gpio_bank_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/gpio_bank_pkg.sv
// rtl/gpio_bank_pkg.sv - register offsets and address-decode constants for gpio_bank_ctrl
package gpio_bank_pkg;

  // Word offset within a port window, taken from A[4:2]
  typedef enum logic [2:0] {
    REG_OUT     = 3'd0,
    REG_DIR,
    REG_IN,
    REG_RISE_EN,
    REG_FALL_EN,
    REG_STAT
  } gpio_reg_e;

  // Byte distance between consecutive port windows
  localparam logic [31:0] PORT_STRIDE = 32'h20;

  // Address bits compared against the base to select the block
  localparam int ADDR_SEL_MSB = 31;
  localparam int ADDR_SEL_LSB = 8;

endpackage

// File: rtl/gpio_edge_sync.sv
// rtl/gpio_edge_sync.sv - per-port input synchroniser, optional debounce (GPIO_DEBOUNCE_EN) and edge detect
module gpio_edge_sync #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pinIn,
  output logic [WIDTH-1:0] filt,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync0;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] filtNext;

  // Two-flop synchroniser for the asynchronous pad inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= pinIn;
      sync1 <= sync0;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [7:0] stableCnt [WIDTH];

  // Accept the synchronised level once it has differed from filt long enough
  always_comb begin
    filtNext = filt;
    for (int i = 0; i < WIDTH; i++) begin
      if ((sync1[i] != filt[i]) && (stableCnt[i] == 8'(DEBOUNCE_CYCLES - 1))) begin
        filtNext[i] = sync1[i];
      end
    end
  end

  // Count consecutive edges of disagreement; any agreement restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        stableCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((sync1[i] == filt[i]) || (filtNext[i] != filt[i])) begin
          stableCnt[i] <= '0;
        end else begin
          stableCnt[i] <= stableCnt[i] + 8'd1;
        end
      end
    end
  end
`else
  logic unusedCfg;
  assign unusedCfg = |8'(DEBOUNCE_CYCLES);

  // Without debounce the filtered level is simply the synchroniser output one edge later
  always_comb begin
    filtNext = sync1;
  end
`endif

  // Filtered level; its current value is the previous sample the edges are judged against
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= '0;
    end else begin
      filt <= filtNext;
    end
  end

  // Edges are reported for the level being loaded so STAT sets on the same edge IN changes
  assign rise = filtNext & ~filt;
  assign fall = ~filtNext & filt;

endmodule

// File: rtl/gpio_bank_ctrl.sv
// rtl/gpio_bank_ctrl.sv - multi-port GPIO register bank with edge-capture irq; GPIO_DEBOUNCE_EN adds input debounce
module gpio_bank_ctrl #(
  parameter int          NUM_PORTS       = 4,
  parameter int          PORT_WIDTH      = 8,
  parameter logic [31:0] BASE_ADDR       = 32'h1001_0000,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            re,
  input  logic                            we,
  input  logic [31:0]                     A,
  input  logic [31:0]                     WD,
  output logic [31:0]                     RD,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_in,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_out,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_oe,
  output logic                            irq
);

  import gpio_bank_pkg::*;

  localparam int PORT_LSB = $clog2(PORT_STRIDE);
  localparam int TOTAL    = NUM_PORTS * PORT_WIDTH;

  logic                  sel;
  logic [2:0]            portIdx;
  logic [2:0]            offset;
  logic [TOTAL-1:0]      outFlat;
  logic [TOTAL-1:0]      dirFlat;
  logic [TOTAL-1:0]      riseEnFlat;
  logic [TOTAL-1:0]      fallEnFlat;
  logic [TOTAL-1:0]      statFlat;
  logic [TOTAL-1:0]      inFlat;
  logic [TOTAL-1:0]      riseFlat;
  logic [TOTAL-1:0]      fallFlat;
  logic [PORT_WIDTH-1:0] portData;
  logic [31:0]           readWord;
  logic                  unusedBits;

  assign sel        = (A[ADDR_SEL_MSB:ADDR_SEL_LSB] == BASE_ADDR[ADDR_SEL_MSB:ADDR_SEL_LSB]);
  assign portIdx    = A[PORT_LSB +: 3];
  assign offset     = A[4:2];
  assign unusedBits = ^{A[1:0], WD};

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : gPort
      logic                  hit;
      logic [PORT_WIDTH-1:0] w1c;
      logic [PORT_WIDTH-1:0] outQ;
      logic [PORT_WIDTH-1:0] dirQ;
      logic [PORT_WIDTH-1:0] riseEnQ;
      logic [PORT_WIDTH-1:0] fallEnQ;
      logic [PORT_WIDTH-1:0] statQ;

      assign hit = sel && (portIdx == 3'(p));
      assign w1c = (we && hit && (offset == REG_STAT)) ? WD[PORT_WIDTH-1:0] : '0;

      gpio_edge_sync #(
        .WIDTH          (PORT_WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) uSync (
        .clk  (clk),
        .rst  (rst),
        .pinIn(gpio_in[p*PORT_WIDTH +: PORT_WIDTH]),
        .filt (inFlat[p*PORT_WIDTH +: PORT_WIDTH]),
        .rise (riseFlat[p*PORT_WIDTH +: PORT_WIDTH]),
        .fall (fallFlat[p*PORT_WIDTH +: PORT_WIDTH])
      );

      // Port register file; STAT capture uses the enables in force before this edge's write
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          outQ    <= '0;
          dirQ    <= '0;
          riseEnQ <= '0;
          fallEnQ <= '0;
          statQ   <= '0;
        end else begin
          if (we && hit) begin
            case (offset)
              REG_OUT:     outQ    <= WD[PORT_WIDTH-1:0];
              REG_DIR:     dirQ    <= WD[PORT_WIDTH-1:0];
              REG_RISE_EN: riseEnQ <= WD[PORT_WIDTH-1:0];
              REG_FALL_EN: fallEnQ <= WD[PORT_WIDTH-1:0];
              default:     ;
            endcase
          end
          statQ <= (statQ & ~w1c)
                 | (riseFlat[p*PORT_WIDTH +: PORT_WIDTH] & riseEnQ)
                 | (fallFlat[p*PORT_WIDTH +: PORT_WIDTH] & fallEnQ);
        end
      end

      assign outFlat[p*PORT_WIDTH +: PORT_WIDTH]    = outQ;
      assign dirFlat[p*PORT_WIDTH +: PORT_WIDTH]    = dirQ;
      assign riseEnFlat[p*PORT_WIDTH +: PORT_WIDTH] = riseEnQ;
      assign fallEnFlat[p*PORT_WIDTH +: PORT_WIDTH] = fallEnQ;
      assign statFlat[p*PORT_WIDTH +: PORT_WIDTH]   = statQ;
    end
  endgenerate

  // Read mux over current register values; absent ports and reserved offsets read 0
  always_comb begin
    portData = '0;
    readWord = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (portIdx == 3'(i)) begin
        case (offset)
          REG_OUT:     portData = outFlat[i*PORT_WIDTH +: PORT_WIDTH];
          REG_DIR:     portData = dirFlat[i*PORT_WIDTH +: PORT_WIDTH];
          REG_IN:      portData = inFlat[i*PORT_WIDTH +: PORT_WIDTH];
          REG_RISE_EN: portData = riseEnFlat[i*PORT_WIDTH +: PORT_WIDTH];
          REG_FALL_EN: portData = fallEnFlat[i*PORT_WIDTH +: PORT_WIDTH];
          REG_STAT:    portData = statFlat[i*PORT_WIDTH +: PORT_WIDTH];
          default:     portData = '0;
        endcase
      end
    end
    if (sel) begin
      readWord[PORT_WIDTH-1:0] = portData;
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RD <= '0;
    end else if (re) begin
      RD <= readWord;
    end
  end

  assign gpio_out = outFlat;
  assign gpio_oe  = dirFlat;
  assign irq      = |statFlat;

endmodule
